// File: rtl/fact_seq_ctrl_pkg.sv
// rtl/fact_seq_ctrl_pkg.sv - shared types and defaults for the factorial sequencer
package fact_seq_ctrl_pkg;

  localparam int N_W_DEF     = 9;
  localparam int D_W_DEF     = 16;
  localparam int MUL_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_NONE = 2'd0,
    ALU_OP_MUL  = 2'd1
  } alu_op_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fact_seq_ctrl_iter_cnt.sv
// rtl/fact_seq_ctrl_iter_cnt.sv - loadable down-counter holding the factorial iteration k
module fact_seq_ctrl_iter_cnt #(
  parameter int N_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           dec,
  input  logic [N_W-1:0] load_val,
  output logic [N_W-1:0] cnt,
  output logic           is_le1,
  output logic           is_two
);

  // load wins over dec; the counter never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_le1 = (cnt <= N_W'(1));
  assign is_two = (cnt == N_W'(2));

endmodule

// File: rtl/fact_seq_ctrl.sv
// rtl/fact_seq_ctrl.sv - factorial sequencer driving the shared ALU multiply
module fact_seq_ctrl
  import fact_seq_ctrl_pkg::*;
#(
  parameter int N_W     = N_W_DEF,
  parameter int D_W     = D_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] val,
  input  logic [D_W-1:0] alu_res,
  input  logic           alu_ovf,
  output logic [D_W-1:0] alu_a,
  output logic [D_W-1:0] alu_b,
  output logic           alu_req,
  output logic           busy,
  output logic           done,
  output logic [D_W-1:0] result,
  output logic           ovf,
  output logic [N_W-1:0] iter
);

  localparam int WCNT_W = cnt_w(MUL_LAT);

  state_t            state_q, state_d;
  alu_op_t           op_sel;
  logic [D_W-1:0]    acc_q, acc_d;
  logic [D_W-1:0]    result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              cnt_load, cnt_dec;
  logic [N_W-1:0]    k;
  logic              k_is_le1, k_is_two;

  fact_seq_ctrl_iter_cnt #(.N_W(N_W)) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (val),
    .cnt      (k),
    .is_le1   (k_is_le1),
    .is_two   (k_is_two)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // RESULT is loaded on the way into DONE so it is already final while DONE is high
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    wcnt_d   = wcnt_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    op_sel   = ALU_OP_NONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          ovf_d    = 1'b0;
          acc_d    = D_W'(1);
          if (val <= N_W'(1)) begin
            result_d = D_W'(1);
            state_d  = ST_DONE;
          end else begin
            result_d = '0;
            state_d  = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        op_sel  = ALU_OP_MUL;
        wcnt_d  = WCNT_W'(MUL_LAT - 1);
        state_d = ST_WAIT;
      end
      // WAIT spans MUL_LAT cycles so ACC samples a product that has settled
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_ACC;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_ACC: begin
        if (alu_ovf) begin
          ovf_d    = 1'b1;
          acc_d    = '1;
          result_d = '1;
          state_d  = ST_DONE;
        end else begin
          acc_d   = alu_res;
          cnt_dec = 1'b1;
          if (k_is_two || k_is_le1) begin
            result_d = alu_res;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign alu_req = (op_sel == ALU_OP_MUL);
  assign alu_a   = alu_req ? acc_q : '0;
  assign alu_b   = alu_req ? D_W'(k) : '0;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign ovf     = ovf_q;
  assign iter    = busy ? k : '0;

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// tb/tb_fact_seq_ctrl.sv - bench for fact_seq_ctrl with MUL_LAT=1 and MUL_LAT=3 instances
module tb_fact_seq_ctrl;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    int          dut;
    int          v;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [8:0]  val;
  logic [15:0] alu_res0, alu_res1;
  logic        alu_ovf0, alu_ovf1;
  logic [15:0] alu_a [2];
  logic [15:0] alu_b [2];
  logic [15:0] result [2];
  logic        alu_req [2];
  logic        busy [2];
  logic        done [2];
  logic        ovf [2];
  logic [8:0]  iter [2];

  logic [31:0] rq0[$], rq1[$];
  exp_t        dq0[$], dq1[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          t0 [2];
  int          ndone [2];
  logic        pbusy [2];
  vec_t        tbl [10];

  always #5 clk = ~clk;

  fact_seq_ctrl #(.MUL_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .val(val),
    .alu_res(alu_res0), .alu_ovf(alu_ovf0),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_req(alu_req[0]),
    .busy(busy[0]), .done(done[0]), .result(result[0]), .ovf(ovf[0]), .iter(iter[0])
  );

  fact_seq_ctrl #(.MUL_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start[1]), .val(val),
    .alu_res(alu_res1), .alu_ovf(alu_ovf1),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_req(alu_req[1]),
    .busy(busy[1]), .done(done[1]), .result(result[1]), .ovf(ovf[1]), .iter(iter[1])
  );

  // behavioural ALUs: product valid MUL_LAT cycles after the request, then held
  logic [31:0] prod0, prod1;
  logic        p_v [2];
  logic [16:0] p_d [2];
  assign prod0 = 32'(alu_a[0]) * 32'(alu_b[0]);
  assign prod1 = 32'(alu_a[1]) * 32'(alu_b[1]);

  always @(posedge clk) begin
    if (rst) begin
      alu_res0 <= '0;
      alu_ovf0 <= 1'b0;
    end else if (alu_req[0]) begin
      alu_res0 <= prod0[15:0];
      alu_ovf0 <= |prod0[31:16];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      p_v[0]   <= 1'b0;
      p_v[1]   <= 1'b0;
      p_d[0]   <= '0;
      p_d[1]   <= '0;
      alu_res1 <= '0;
      alu_ovf1 <= 1'b0;
    end else begin
      p_v[0] <= alu_req[1];
      p_d[0] <= {|prod1[31:16], prod1[15:0]};
      p_v[1] <= p_v[0];
      p_d[1] <= p_d[0];
      if (p_v[1]) {alu_ovf1, alu_res1} <= p_d[1];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int qsize_r(input int d);
    return (d == 0) ? rq0.size() : rq1.size();
  endfunction

  function automatic int qsize_d(input int d);
    return (d == 0) ? dq0.size() : dq1.size();
  endfunction

  task automatic push_r(input int d, input logic [31:0] v);
    if (d == 0) rq0.push_back(v); else rq1.push_back(v);
  endtask

  task automatic pop_r(input int d, output logic [31:0] v);
    if (d == 0) v = rq0.pop_front(); else v = rq1.pop_front();
  endtask

  task automatic push_d(input int d, input exp_t e);
    if (d == 0) dq0.push_back(e); else dq1.push_back(e);
  endtask

  task automatic pop_d(input int d, output exp_t e);
    if (d == 0) e = dq0.pop_front(); else e = dq1.pop_front();
  endtask

  // one cycle: advance to the falling edge and score both DUTs
  task automatic tick();
    logic [31:0] ab;
    exp_t        e;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (busy[d] && !pbusy[d]) t0[d] = cyc;
      pbusy[d] = busy[d];
      if (alu_req[d]) begin
        if (qsize_r(d) == 0) begin
          chk("spurious_req", 32'(alu_req[d]), 32'd0);
        end else begin
          pop_r(d, ab);
          chk("alu_a", 32'(alu_a[d]), 32'(ab[31:16]));
          chk("alu_b", 32'(alu_b[d]), 32'(ab[15:0]));
        end
      end else begin
        chk("alu_ab_idle", {alu_a[d], alu_b[d]}, 32'd0);
      end
      if (done[d]) begin
        ndone[d]++;
        if (qsize_d(d) == 0) begin
          chk("spurious_done", 32'(done[d]), 32'd0);
        end else begin
          pop_d(d, e);
          chk("result", 32'(result[d]), 32'(e.res));
          chk("ovf", 32'(ovf[d]), 32'(e.ovf));
          if (e.lat >= 0) chk("latency", 32'(cyc - t0[d]), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic model(input int d, input int v, input logic [15:0] er, input logic eo);
    logic [31:0] acc, prod;
    int          k, n;
    exp_t        e;
    acc = 32'd1;
    k   = v;
    n   = 0;
    if (v > 1) begin
      while (k > 1) begin
        push_r(d, {acc[15:0], 16'(k)});
        prod = acc * 32'(k);
        n++;
        if (prod > 32'h0000_FFFF) break;
        acc = prod;
        k--;
      end
    end
    e.res = er;
    e.ovf = eo;
    e.lat = (v <= 1) ? -1 : n * ((d == 0) ? 3 : 5);
    push_d(d, e);
  endtask

  task automatic wait_done(input int d, input int target);
    for (int i = 0; i < 400 && ndone[d] < target; i++) tick();
    chk("done_seen", 32'(ndone[d] >= target), 32'd1);
  endtask

  task automatic launch(input int d, input int v, input logic [15:0] er, input logic eo,
                        output int target);
    model(d, v, er, eo);
    target   = ndone[d] + 1;
    val      = 9'(v);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    val      = 9'($urandom);
    chk("iter_load", 32'(iter[d]), 32'(v));
    if (v <= 1) chk("short_done", 32'(done[d]), 32'd1);
  endtask

  task automatic finish_run(input int d, input int target);
    wait_done(d, target);
    tick();
    chk("idle_busy", 32'(busy[d]), 32'd0);
    chk("idle_iter", 32'(iter[d]), 32'd0);
    chk("req_drained", 32'(qsize_r(d)), 32'd0);
  endtask

  task automatic chk_zero(input int d);
    chk("zero_alu_a", 32'(alu_a[d]), 32'd0);
    chk("zero_alu_b", 32'(alu_b[d]), 32'd0);
    chk("zero_alu_req", 32'(alu_req[d]), 32'd0);
    chk("zero_busy", 32'(busy[d]), 32'd0);
    chk("zero_done", 32'(done[d]), 32'd0);
    chk("zero_result", 32'(result[d]), 32'd0);
    chk("zero_ovf", 32'(ovf[d]), 32'd0);
    chk("zero_iter", 32'(iter[d]), 32'd0);
  endtask

  initial begin
    int target;
    tbl[0] = '{0, 5,   16'd120,   1'b0};
    tbl[1] = '{0, 0,   16'd1,     1'b0};
    tbl[2] = '{0, 1,   16'd1,     1'b0};
    tbl[3] = '{0, 8,   16'd40320, 1'b0};
    tbl[4] = '{0, 9,   16'hFFFF,  1'b1};
    tbl[5] = '{0, 2,   16'd2,     1'b0};
    tbl[6] = '{0, 7,   16'd5040,  1'b0};
    tbl[7] = '{0, 511, 16'hFFFF,  1'b1};
    tbl[8] = '{1, 4,   16'd24,    1'b0};
    tbl[9] = '{1, 5,   16'd120,   1'b0};

    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    val      = '0;
    for (int d = 0; d < 2; d++) begin
      t0[d]    = 0;
      ndone[d] = 0;
      pbusy[d] = 1'b0;
    end
    repeat (3) tick();
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].dut, tbl[i].v, tbl[i].res, tbl[i].ovf, target);
      finish_run(tbl[i].dut, target);
    end

    // START pulses with a different operand while busy must be dropped
    launch(0, 5, 16'd120, 1'b0, target);
    for (int i = 0; i < 4; i++) begin
      val      = 9'd3;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      chk("busy_hold", 32'(busy[0]), 32'd1);
      tick();
    end
    finish_run(0, target);

    // reset mid-run aborts with no DONE; a fresh run then completes
    launch(0, 6, 16'd720, 1'b0, target);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_zero(0);
    rst = 1'b0;
    rq0.delete();
    dq0.delete();
    repeat (6) tick();
    chk("abort_no_done", 32'(ndone[0]), 32'(target - 1));
    launch(0, 4, 16'd24, 1'b0, target);
    finish_run(0, target);

    // START held high across DONE restarts from IDLE on the following cycle
    model(0, 2, 16'd2, 1'b0);
    model(0, 2, 16'd2, 1'b0);
    target   = ndone[0] + 2;
    val      = 9'd2;
    start[0] = 1'b1;
    wait_done(0, target - 1);
    tick();
    chk("restart_idle", 32'(busy[0]), 32'd0);
    tick();
    chk("restart_busy", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    finish_run(0, target);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
